// File: rtl/sprite_rom_burst.sv
// Sprite ROM with a burst fetch engine: one accepted request streams req_len
// consecutive words, one per cycle, with valid/last tags aligned to the data.
module sprite_rom_burst #(
    parameter string INIT_FILE  = "",
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 8,
    parameter int    MAX_BURST  = 64,
    parameter int    OUT_REG    = 0,
    localparam int   DEPTH      = 2 ** ADDR_WIDTH,
    localparam int   LEN_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last
);

    localparam int LAT = 1 + OUT_REG;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic                  issue_valid;
    logic                  issue_last;

    // Tag and data pipeline; stage 0 is the ROM read register itself.
    logic [LAT-1:0]        valid_pipe;
    logic [LAT-1:0]        last_pipe;
    logic [DATA_WIDTH-1:0] data_pipe [LAT];

    assign len_clamped = (req_len > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : req_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        req_ready      = 1'b0;
        issue_valid    = 1'b0;
        issue_last     = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                // Zero-length requests are consumed here without leaving IDLE.
                if (req_valid && (len_clamped != '0)) begin
                    addr_next      = req_base;
                    remaining_next = len_clamped;
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                issue_valid    = 1'b1;
                addr_next      = addr_reg + ADDR_WIDTH'(1);
                remaining_next = remaining_reg - LEN_WIDTH'(1);
                if (remaining_reg == LEN_WIDTH'(1)) begin
                    issue_last = 1'b1;
                    state_next = (OUT_REG != 0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Data stages only load on a valid word so dout holds after the burst ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_pipe[i] <= '0;
            end
        end else begin
            valid_pipe[0] <= issue_valid;
            last_pipe[0]  <= issue_last;
            if (issue_valid) data_pipe[0] <= mem[addr_reg];
            for (int i = 1; i < LAT; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
                if (valid_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign dout_valid = valid_pipe[LAT-1];
    assign dout_last  = last_pipe[LAT-1];
    assign dout       = data_pipe[LAT-1];

    always @(posedge clk) begin
        if (!reset && (state_reg == IDLE) && req_valid) begin
            assert (req_len <= LEN_WIDTH'(MAX_BURST))
            else $warning("sprite_rom_burst: req_len %0d exceeds MAX_BURST %0d, clamped",
                          req_len, MAX_BURST);
        end
    end

endmodule

// File: tb/tb_sprite_rom_burst.sv
// Directed bench for sprite_rom_burst: one instance without and one with the
// output register stage, ROM preloaded with ROM[i] = i*3.
module tb_sprite_rom_burst;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int MB  = 64;
    localparam int LW  = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    logic          rv0 = 1'b0, rv1 = 1'b0;
    logic [AW-1:0] rb0 = '0, rb1 = '0;
    logic [LW-1:0] rl0 = '0, rl1 = '0;
    logic          ready0, ready1;
    logic          valid0, valid1;
    logic [DW-1:0] dout0, dout1;
    logic          last0, last1;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    sprite_rom_burst #(
        .INIT_FILE(""), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .OUT_REG(0)
    ) u0 (
        .clk(clk), .reset(reset),
        .req_valid(rv0), .req_ready(ready0), .req_base(rb0), .req_len(rl0),
        .dout_valid(valid0), .dout(dout0), .dout_last(last0)
    );

    sprite_rom_burst #(
        .INIT_FILE(""), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .OUT_REG(1)
    ) u1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(ready1), .req_base(rb1), .req_len(rl1),
        .dout_valid(valid1), .dout(dout1), .dout_last(last1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks valid, data (only when valid expected), last and ready of instance 0.
    task automatic chk0(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic r);
        chk({tag, ".valid"}, 32'(valid0), 32'(v));
        if (v) chk({tag, ".dout"}, 32'(dout0), 32'(d));
        chk({tag, ".last"}, 32'(last0), 32'(l));
        chk({tag, ".ready"}, 32'(ready0), 32'(r));
    endtask

    task automatic chk1(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic r);
        chk({tag, ".valid"}, 32'(valid1), 32'(v));
        if (v) chk({tag, ".dout"}, 32'(dout1), 32'(d));
        chk({tag, ".last"}, 32'(last1), 32'(l));
        chk({tag, ".ready"}, 32'(ready1), 32'(r));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words;
        int lasts;
        for (int i = 0; i < 256; i++) begin
            u0.mem[i] = 16'(i * 3);
            u1.mem[i] = 16'(i * 3);
        end

        // Reset state
        tick();
        tick();
        chk0("reset0", 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("reset0.dout", 32'(dout0), 32'h0);
        chk1("reset1", 1'b0, 16'h0000, 1'b0, 1'b1);
        reset = 1'b0;

        // Basic burst, OUT_REG=0
        rv0 = 1'b1; rb0 = 8'h10; rl0 = 7'd4;
        tick();                                   // E0
        rv0 = 1'b0;
        chk0("basic.E0", 1'b0, 16'h0, 1'b0, 1'b0);
        tick(); chk0("basic.E1", 1'b1, 16'h0030, 1'b0, 1'b0);
        tick(); chk0("basic.E2", 1'b1, 16'h0033, 1'b0, 1'b0);
        tick(); chk0("basic.E3", 1'b1, 16'h0036, 1'b0, 1'b0);
        tick(); chk0("basic.E4", 1'b1, 16'h0039, 1'b1, 1'b1);
        tick(); chk0("basic.E5", 1'b0, 16'h0, 1'b0, 1'b1);
        chk("basic.hold", 32'(dout0), 32'h0039);
        $display("burst base=10 len=4 OUT_REG=0 done");

        // Wrap-around
        rv0 = 1'b1; rb0 = 8'hFE; rl0 = 7'd4;
        tick();
        rv0 = 1'b0;
        tick(); chk0("wrap.w0", 1'b1, 16'h02FA, 1'b0, 1'b0);
        tick(); chk0("wrap.w1", 1'b1, 16'h02FD, 1'b0, 1'b0);
        tick(); chk0("wrap.w2", 1'b1, 16'h0000, 1'b0, 1'b0);
        tick(); chk0("wrap.w3", 1'b1, 16'h0003, 1'b1, 1'b1);
        tick(); chk0("wrap.end", 1'b0, 16'h0, 1'b0, 1'b1);
        $display("burst base=fe len=4 wrap done");

        // Zero length
        rv0 = 1'b1; rb0 = 8'h22; rl0 = 7'd0;
        tick(); chk0("zero.E0", 1'b0, 16'h0, 1'b0, 1'b1);
        rv0 = 1'b0;
        tick(); chk0("zero.E1", 1'b0, 16'h0, 1'b0, 1'b1);
        tick(); chk0("zero.E2", 1'b0, 16'h0, 1'b0, 1'b1);
        $display("burst len=0 dropped");

        // Clamp: MAX_BURST+1 requested, MAX_BURST words expected
        rv0 = 1'b1; rb0 = 8'h00; rl0 = 7'(MB + 1);
        tick();
        rv0 = 1'b0;
        words = 0;
        lasts = 0;
        for (int c = 0; c < MB + 6; c++) begin
            tick();
            if (valid0) begin
                chk($sformatf("clamp.w%0d", words), 32'(dout0), 32'(words * 3));
                words++;
                if (last0) lasts++;
            end
        end
        chk("clamp.words", 32'(words), 32'(MB));
        chk("clamp.lasts", 32'(lasts), 32'd1);
        chk("clamp.ready", 32'(ready0), 32'd1);
        $display("burst len=%0d clamped, %0d words", MB + 1, words);

        // Back-to-back with req_valid held high
        rv0 = 1'b1; rb0 = 8'h20; rl0 = 7'd3;
        tick();                                   // E0 first acceptance
        rb0 = 8'h40; rl0 = 7'd2;
        tick(); chk0("b2b.E1", 1'b1, 16'h0060, 1'b0, 1'b0);
        tick(); chk0("b2b.E2", 1'b1, 16'h0063, 1'b0, 1'b0);
        tick(); chk0("b2b.E3", 1'b1, 16'h0066, 1'b1, 1'b1);
        tick(); chk0("b2b.E4gap", 1'b0, 16'h0, 1'b0, 1'b0);  // second acceptance at E4
        rv0 = 1'b0;
        tick(); chk0("b2b.E5", 1'b1, 16'h00C0, 1'b0, 1'b0);
        tick(); chk0("b2b.E6", 1'b1, 16'h00C3, 1'b1, 1'b1);
        tick(); chk0("b2b.E7", 1'b0, 16'h0, 1'b0, 1'b1);
        $display("burst pair base=20/40 len=3/2 back-to-back done");

        // OUT_REG=1 latency
        rv1 = 1'b1; rb1 = 8'h00; rl1 = 7'd2;
        tick();                                   // E0
        rv1 = 1'b0;
        chk1("lat.E0", 1'b0, 16'h0, 1'b0, 1'b0);
        tick(); chk1("lat.E1", 1'b0, 16'h0, 1'b0, 1'b0);
        tick(); chk1("lat.E2", 1'b1, 16'h0000, 1'b0, 1'b0);
        chk("lat.drain", 32'(u1.state_reg), 32'd2);
        tick(); chk1("lat.E3", 1'b1, 16'h0003, 1'b1, 1'b1);
        chk("lat.idle", 32'(u1.state_reg), 32'd0);
        tick(); chk1("lat.E4", 1'b0, 16'h0, 1'b0, 1'b1);
        chk("lat.hold", 32'(dout1), 32'h0003);
        $display("burst base=00 len=2 OUT_REG=1 done");

        // Reset mid-burst
        rv0 = 1'b1; rb0 = 8'h80; rl0 = 7'd8;
        tick();
        rv0 = 1'b0;
        tick(); chk0("rst.w0", 1'b1, 16'h0180, 1'b0, 1'b0);
        tick(); chk0("rst.w1", 1'b1, 16'h0183, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk0("rst.async", 1'b0, 16'h0, 1'b0, 1'b1);
        chk("rst.dout", 32'(dout0), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick(); chk0("rst.quiet", 1'b0, 16'h0, 1'b0, 1'b1);
        rv0 = 1'b1; rb0 = 8'h05; rl0 = 7'd1;
        tick();
        rv0 = 1'b0;
        chk0("rst.newE0", 1'b0, 16'h0, 1'b0, 1'b0);
        tick(); chk0("rst.newE1", 1'b1, 16'h000F, 1'b1, 1'b1);
        tick(); chk0("rst.newE2", 1'b0, 16'h0, 1'b0, 1'b1);
        $display("burst aborted by reset, new base=05 len=1 done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
